// File: rtl/mdu_sequencer.sv
// Multiply/divide iteration sequencer: LOAD, PAR x ITER, optional FIX, DONE.
// Optional macro MDU_ZERO_BYPASS_EN: divide-by-zero skips ITER/FIX.
module mdu_sequencer #(
   parameter  int PAR          = 32,
   parameter  int OPCODE_WIDTH = 3,
   localparam int CNT_W        = $clog2(PAR + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    validIn,
   output logic                    readyOut,
   input  logic [OPCODE_WIDTH-1:0] opCode,
   input  logic                    flush,
   input  logic                    divisorZero,
   output logic                    loadOperands,
   output logic                    iterEn,
   output logic                    fixEn,
   output logic [CNT_W-1:0]        iterCount,
   output logic                    selHigh,
   output logic                    zeroBypass,
   output logic                    busy,
   output logic                    validOut,
   input  logic                    readyIn
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PAR - 1);

   state_t                  r_state;
   state_t                  w_next;
   logic [OPCODE_WIDTH-1:0] r_op;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_zb;
   logic                    w_bypass;
   logic                    w_accept;
   logic                    w_sel;

   assign w_accept = validIn && (r_state == S_IDLE);

`ifdef MDU_ZERO_BYPASS_EN
   assign w_bypass = r_op[2] && divisorZero;
`else
   logic w_unused_dz;
   assign w_unused_dz = divisorZero;
   assign w_bypass    = 1'b0;
`endif

   // upper word for MULH*, remainder for REM*
   assign w_sel = r_op[2] ? r_op[1] : (r_op[1:0] != 2'b00);

   // state, opcode, iteration counter and bypass flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_cnt   <= '0;
         r_zb    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept)
            r_op <= opCode;
         if (flush || r_state != S_ITER)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CNT_W'(1);
         if (r_state == S_LOAD)
            r_zb <= w_bypass;
         else if (r_state != S_DONE)
            r_zb <= 1'b0;
      end
   end

   // next-state logic; flush aborts everything except the idle accept
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (validIn) w_next = S_LOAD;
         S_LOAD: w_next = w_bypass ? S_DONE : S_ITER;
         S_ITER: if (r_cnt == LAST)
                    w_next = r_op[2] ? S_FIX : S_DONE;
         S_FIX:  w_next = S_DONE;
         S_DONE: if (readyIn) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush && r_state != S_IDLE)
         w_next = S_IDLE;
   end

   // Moore outputs decoded from the current state
   always_comb begin
      readyOut     = 1'b0;
      loadOperands = 1'b0;
      iterEn       = 1'b0;
      fixEn        = 1'b0;
      iterCount    = '0;
      validOut     = 1'b0;
      zeroBypass   = 1'b0;
      busy         = (r_state != S_IDLE);
      selHigh      = (r_state != S_IDLE) && w_sel;
      unique case (r_state)
         S_IDLE: readyOut = 1'b1;
         S_LOAD: loadOperands = 1'b1;
         S_ITER: begin
            iterEn    = 1'b1;
            iterCount = r_cnt;
         end
         S_FIX:  fixEn = 1'b1;
         S_DONE: begin
            validOut   = 1'b1;
            zeroBypass = r_zb;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer (PAR=32).
// Expected latency/select/bypass pushed at accept, checked at validOut.
module tb_mdu_sequencer;

   localparam int PAR   = 32;
   localparam int CNT_W = $clog2(PAR + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             validIn = 1'b0;
   logic             readyOut;
   logic [2:0]       opCode = '0;
   logic             flush = 1'b0;
   logic             divisorZero = 1'b0;
   logic             loadOperands;
   logic             iterEn;
   logic             fixEn;
   logic [CNT_W-1:0] iterCount;
   logic             selHigh;
   logic             zeroBypass;
   logic             busy;
   logic             validOut;
   logic             readyIn = 1'b0;

   typedef struct {
      int   lat;
      int   niter;
      int   nfix;
      logic sel;
      logic zb;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   mdu_sequencer #(.PAR(PAR), .OPCODE_WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .validIn(validIn), .readyOut(readyOut),
      .opCode(opCode), .flush(flush), .divisorZero(divisorZero),
      .loadOperands(loadOperands), .iterEn(iterEn), .fixEn(fixEn),
      .iterCount(iterCount), .selHigh(selHigh), .zeroBypass(zeroBypass),
      .busy(busy), .validOut(validOut), .readyIn(readyIn)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // called at a negedge in IDLE; returns at a negedge back in IDLE
   task automatic run_op(input logic [2:0] op, input logic dz,
                         input int hold);
      exp_t e;
      int   cyc, nload, niter, nfix, serr, herr;
      bit   seen;
      e.sel   = op[2] ? op[1] : (op[1:0] != 2'b00);
      e.nfix  = op[2] ? 1 : 0;
      e.niter = PAR;
      e.lat   = op[2] ? PAR + 3 : PAR + 2;
      e.zb    = 1'b0;
`ifdef MDU_ZERO_BYPASS_EN
      if (op[2] && dz) begin
         e.lat = 2; e.nfix = 0; e.niter = 0; e.zb = 1'b1;
      end
`endif
      n_tot++;
      if (readyOut !== 1'b1)
         $display("FAIL op%b_ready: got %b want 1", op, readyOut);
      else n_pass++;
      validIn = 1'b1; opCode = op; divisorZero = dz; readyIn = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      validIn = 1'b0; opCode = ~op;
      cyc = 1; seen = 0; nload = 0; niter = 0; nfix = 0; serr = 0;
      while (cyc <= 60 && !seen) begin
         if (validOut === 1'b1) seen = 1;
         else begin
            if (int'(loadOperands) + int'(iterEn) + int'(fixEn) > 1) serr++;
            if (loadOperands) begin
               nload++;
               if (cyc != 1) serr++;
            end
            if (iterEn) begin
               if (iterCount !== CNT_W'(niter)) serr++;
               niter++;
            end
            if (fixEn) nfix++;
            if (busy !== 1'b1 || selHigh !== e.sel) serr++;
            @(negedge clk);
            cyc++;
         end
      end
      e = sb.pop_front();
      n_tot++;
      if (!seen) begin
         $display("FAIL op%b_timeout: validOut not seen in %0d cycles",
                  op, cyc);
         readyIn = 1'b1; @(negedge clk); readyIn = 1'b0;
         return;
      end
      n_pass++;
      n_tot++;
      if (cyc != e.lat)
         $display("FAIL op%b_latency: got %0d want %0d", op, cyc, e.lat);
      else n_pass++;
      n_tot++;
      if (selHigh !== e.sel || zeroBypass !== e.zb)
         $display("FAIL op%b_sel_zb: got %b%b want %b%b",
                  op, selHigh, zeroBypass, e.sel, e.zb);
      else n_pass++;
      n_tot++;
      if (nload != 1 || niter != e.niter || nfix != e.nfix)
         $display("FAIL op%b_strobes: load/iter/fix got %0d/%0d/%0d want 1/%0d/%0d",
                  op, nload, niter, nfix, e.niter, e.nfix);
      else n_pass++;
      n_tot++;
      if (serr != 0)
         $display("FAIL op%b_cycle: %0d per-cycle errors want 0", op, serr);
      else n_pass++;
      herr = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (validOut !== 1'b1 || selHigh !== e.sel || readyOut !== 1'b0)
            herr++;
      end
      if (hold > 0) begin
         n_tot++;
         if (herr != 0)
            $display("FAIL op%b_hold: %0d unstable cycles want 0", op, herr);
         else n_pass++;
      end
      readyIn = 1'b1;
      @(negedge clk);
      readyIn = 1'b0;
      n_tot++;
      if ({readyOut, busy, validOut} !== 3'b100)
         $display("FAIL op%b_release: rdy/busy/vld got %b want 100",
                  op, {readyOut, busy, validOut});
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_tot++;
      if ({readyOut, busy, validOut, loadOperands, iterEn, fixEn,
           selHigh, zeroBypass, iterCount} !== {1'b1, 13'b0})
         $display("FAIL reset_outputs: got %b want %b",
                  {readyOut, busy, validOut, loadOperands, iterEn, fixEn,
                   selHigh, zeroBypass, iterCount}, {1'b1, 13'b0});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_flush();
      bit hit;
      validIn = 1'b1; opCode = 3'b011;
      @(negedge clk);
      validIn = 1'b0;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (iterEn && iterCount == CNT_W'(10)) hit = 1;
         else @(negedge clk);
      end
      n_tot++;
      if (!hit) $display("FAIL flush_reach: iterCount 10 not seen");
      else n_pass++;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_tot++;
      if ({readyOut, busy, validOut, iterEn} !== 4'b1000)
         $display("FAIL flush_idle: rdy/busy/vld/iter got %b want 1000",
                  {readyOut, busy, validOut, iterEn});
      else n_pass++;
      run_op(3'b000, 1'b0, 0);
   endtask

   task automatic test_flush_in_idle();
      validIn = 1'b1; flush = 1'b1; opCode = 3'b100;
      @(negedge clk);
      validIn = 1'b0;
      n_tot++;
      if (loadOperands !== 1'b1)
         $display("FAIL flush_accept: loadOperands got %b want 1",
                  loadOperands);
      else n_pass++;
      @(negedge clk);
      flush = 1'b0;
      n_tot++;
      if ({readyOut, busy} !== 2'b10)
         $display("FAIL flush_load: rdy/busy got %b want 10",
                  {readyOut, busy});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      validIn = 1'b1; opCode = 3'b100;
      @(negedge clk);
      validIn = 1'b0;
      repeat (10) @(negedge clk);
      n_tot++;
      if (iterEn !== 1'b1)
         $display("FAIL rstmid_iter: iterEn got %b want 1", iterEn);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_tot++;
      if ({readyOut, busy, iterEn, validOut} !== 4'b1000)
         $display("FAIL rstmid_async: rdy/busy/iter/vld got %b want 1000",
                  {readyOut, busy, iterEn, validOut});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(3'b100, 1'b0, 0);
   endtask

   initial begin
      logic [2:0] ops [4];
      ops = '{3'b000, 3'b001, 3'b010, 3'b111};
      test_reset();
      run_op(3'b011, 1'b0, 0);
      run_op(3'b100, 1'b0, 0);
      run_op(3'b110, 1'b0, 5);
      test_flush();
      test_flush_in_idle();
      run_op(3'b101, 1'b1, 0);
      test_reset_mid();
      for (int i = 0; i < 4; i++)
         run_op(ops[i], 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      n_tot++;
      if (sb.size() != 0)
         $display("FAIL sb_empty: %0d entries left want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
